// File: rtl/dff_char_sequencer.sv
// dff_char_sequencer
//
// Purpose: on-chip stimulus and checker sequencer for the setup-time
// characterization of one D flip-flop. It sweeps a delay-line code from
// CODE_MAX down to 0. Each step runs these phases:
//   - CLR:    clear the DUT to 0 with a capture strobe.
//   - HOLD:   check that the DUT reads 0 (init check).
//   - LAUNCH: drive a 1 together with a capture strobe that the external
//             delay line skews by delay_code.
//   - SETTLE: check that the DUT reads 1 (data check).
// The block records where capture first fails.
//
// Optional feature: define DFF_CHAR_SWEEP_ALL_EN to keep sweeping after a
// failure, down to code 0, and count every failing step. When it is not
// defined, the sweep stops after the first failing step.
//
// Ports:
//   clk         sole clock
//   rst_n       asynchronous active-low reset
//   start       one-cycle sweep request, honoured only in IDLE
//   dut_dout    DUT flop output (already synchronous to clk)
//   dut_din     DUT data input
//   cap_pulse   one-cycle capture strobe, sent to the delay line
//   delay_code  delay line setting
//   busy        high from start acceptance until the sweep ends
//   done        one-cycle pulse at sweep end
//   fail_found  at least one step failed
//   fail_code   highest (first) failing code
//   fail_count  number of failing steps, saturating
module dff_char_sequencer #(
  parameter int CODE_W   = 7,
  parameter int CODE_MAX = 100,
  parameter int TICK     = 4,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              dut_dout,
  output logic              dut_din,
  output logic              cap_pulse,
  output logic [CODE_W-1:0] delay_code,
  output logic              busy,
  output logic              done,
  output logic              fail_found,
  output logic [CODE_W-1:0] fail_code,
  output logic [CNT_W-1:0]  fail_count
);

  typedef enum logic [2:0] {IDLE, CLR, HOLD, LAUNCH, SETTLE, NEXT, FIN} state_t;

  localparam int TW = $clog2(TICK + 1);
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(TICK - 2);

  state_t        state, state_nxt;
  logic [TW-1:0] tick_cnt;
  logic          step_fail;
  logic          clr_last, hold_last, settle_last;
  logic          init_bad, data_bad, step_bad, stop;

  assign clr_last    = (state == CLR)    && (tick_cnt == TICK_LAST);
  assign hold_last   = (state == HOLD)   && (tick_cnt == TICK_LAST);
  assign settle_last = (state == SETTLE) && (tick_cnt == SETTLE_LAST);

  assign init_bad = hold_last && dut_dout;
  assign data_bad = settle_last && !dut_dout;
  // A step that already failed its init check is counted only once, here.
  assign step_bad = step_fail || data_bad;

`ifdef DFF_CHAR_SWEEP_ALL_EN
  assign stop = (delay_code == '0);
`else
  assign stop = step_fail || (delay_code == '0);
`endif

  // The phase counter restarts on every state change, so each phase
  // measures its own length from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= (state_nxt != state) ? '0 : tick_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)       state_nxt = CLR;
      CLR:     if (clr_last)    state_nxt = HOLD;
      HOLD:    if (hold_last)   state_nxt = LAUNCH;
      LAUNCH:                   state_nxt = SETTLE;
      SETTLE:  if (settle_last) state_nxt = NEXT;
      NEXT:                     state_nxt = stop ? FIN : CLR;
      FIN:                      state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dut_din   = (state == LAUNCH) || (state == SETTLE);
    cap_pulse = clr_last || (state == LAUNCH);
    done      = (state == FIN);
  end

  // The step verdict is written at the end of SETTLE, so step_fail is
  // already valid when NEXT decides whether to stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_code <= '0;
      busy       <= 1'b0;
      fail_found <= 1'b0;
      fail_code  <= '0;
      fail_count <= '0;
      step_fail  <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        delay_code <= CODE_W'(CODE_MAX);
        busy       <= 1'b1;
        fail_found <= 1'b0;
        fail_code  <= '0;
        fail_count <= '0;
        step_fail  <= 1'b0;
      end
      if (init_bad) begin
        step_fail <= 1'b1;
      end
      if (settle_last && step_bad) begin
        step_fail <= 1'b1;
        if (!fail_found) begin
          fail_found <= 1'b1;
          fail_code  <= delay_code;
        end
        if (fail_count != '1) begin
          fail_count <= fail_count + 1'b1;
        end
      end
      if (state == NEXT) begin
        step_fail <= 1'b0;
        if (!stop) begin
          delay_code <= delay_code - 1'b1;
        end
      end
      if (state == FIN) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dff_char_sequencer.sv
// tb_dff_char_sequencer
//
// Purpose: self-checking bench for dff_char_sequencer. A behavioural flop
// stands in for the DUT. It captures dut_din on cap_pulse only when
// delay_code >= k, or it can be forced stuck at 1 or stuck at 0.
// Expected results come from a step-level model: a step fails when the flop
// is stuck, or when its code is below k.
module tb_dff_char_sequencer;

  localparam int CODE_W   = 7;
  localparam int CODE_MAX = 100;
  localparam int TICK     = 4;
  localparam int CNT_W    = 8;
  localparam int STEP     = 3 * TICK + 1;
  localparam int BUDGET   = 3000;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              dut_dout;
  logic              dut_din;
  logic              cap_pulse;
  logic [CODE_W-1:0] delay_code;
  logic              busy;
  logic              done;
  logic              fail_found;
  logic [CODE_W-1:0] fail_code;
  logic [CNT_W-1:0]  fail_count;

  int   checks = 0;
  int   errors = 0;
  int   k      = 0;
  int   mode   = 0;
  logic flop_q;

  dff_char_sequencer #(
    .CODE_W  (CODE_W),
    .CODE_MAX(CODE_MAX),
    .TICK    (TICK),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dut_dout  (dut_dout),
    .dut_din   (dut_din),
    .cap_pulse (cap_pulse),
    .delay_code(delay_code),
    .busy      (busy),
    .done      (done),
    .fail_found(fail_found),
    .fail_code (fail_code),
    .fail_count(fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural flop under test: the capture lands only if the delay is long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flop_q <= 1'b0;
    else if (cap_pulse && (int'(delay_code) >= k)) flop_q <= dut_din;
  end

  assign dut_dout = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : flop_q;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] packedOutputs();
    return 32'({dut_din, cap_pulse, delay_code, busy, done, fail_found, fail_code, fail_count});
  endfunction

  // Step-level reference: walks the codes and applies the failure rule directly.
  task automatic modelSweep(input int k_in, input int mode_in,
                            output int e_found, output int e_code, output int e_count,
                            output int e_final, output int e_done);
    int steps;
    bit fails;
    e_found = 0; e_code = 0; e_count = 0; e_final = 0; steps = 0;
    for (int c = CODE_MAX; c >= 0; c--) begin
      fails = (mode_in != 0) || (c < k_in);
      steps++;
      e_final = c;
      if (fails) begin
        if (e_found == 0) begin
          e_found = 1;
          e_code  = c;
        end
        if (e_count < (1 << CNT_W) - 1) e_count++;
`ifndef DFF_CHAR_SWEEP_ALL_EN
        break;
`endif
      end
    end
    e_done = steps * STEP + 1;
  endtask

  task automatic applyStimulus(input int k_in, input int mode_in,
                               input int poke_start_at, input int reset_at);
    int   e_found, e_code, e_count, e_final, e_done;
    int   cyc;
    int   consec;
    int   done_in_reset;
    logic prev_cap;
    bit   aborted;
    k    = k_in;
    mode = mode_in;
    modelSweep(k_in, mode_in, e_found, e_code, e_count, e_final, e_done);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1; consec = 0; prev_cap = 1'b0; aborted = 1'b0;
    while (cyc < BUDGET) begin
      @(negedge clk);
      if (cyc == 1) begin
        checkOutput("busy_first", 32'(busy), 32'd1);
        checkOutput("code_first", 32'(delay_code), 32'(CODE_MAX));
      end
      if (cap_pulse && prev_cap) consec++;
      prev_cap = cap_pulse;
      if (cyc == poke_start_at) start = 1'b1;
      if (cyc == reset_at) begin
        rst_n = 1'b0;
        #1 checkOutput("reset_mid", packedOutputs(), 32'd0);
        done_in_reset = 0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          if (done) done_in_reset++;
        end
        rst_n = 1'b1;
        checkOutput("reset_no_done", 32'(done_in_reset), 32'd0);
        checkOutput("reset_held", packedOutputs(), 32'd0);
        aborted = 1'b1;
        break;
      end
      if (done) break;
      @(posedge clk);
      #1 start = 1'b0;
      cyc++;
    end
    if (!aborted) begin
      checkOutput("done_cycle", 32'(cyc), 32'(e_done));
      checkOutput("fail_found", 32'(fail_found), 32'(e_found));
      checkOutput("fail_code", 32'(fail_code), 32'(e_code));
      checkOutput("fail_count", 32'(fail_count), 32'(e_count));
      checkOutput("final_code", 32'(delay_code), 32'(e_final));
      checkOutput("cap_consec", 32'(consec), 32'd0);
      @(negedge clk);
      checkOutput("done_pulse", 32'(done), 32'd0);
      checkOutput("busy_after", 32'(busy), 32'd0);
      checkOutput("code_hold", 32'(delay_code), 32'(e_final));
    end
  endtask

  initial begin
    start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_init", packedOutputs(), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(37, 0, -1, -1);
    applyStimulus(0, 0, 200, -1);
    applyStimulus(37, 0, -1, -1);
    applyStimulus(0, 1, -1, -1);
    applyStimulus(0, 2, -1, -1);
    applyStimulus(0, 0, -1, 500);
    repeat (5) @(negedge clk);
    checkOutput("idle_after_reset", 32'(busy), 32'd0);
    applyStimulus(0, 0, -1, -1);
    for (int r = 0; r < 4; r++) begin
      int rk, rm;
      rk = int'($urandom_range(0, CODE_MAX + 1));
      rm = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 2)) : 0;
      applyStimulus(rk, rm, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_char_sequencer.md
# dff_char_sequencer

Synthesizable on-chip stimulus and checker sequencer for setup-time characterization of a single D flip-flop under test. It sweeps a delay code from a maximum down to zero. At each code it drives the DUT data input low, then high, fires a capture pulse that an external programmable delay line skews by `delay_code`, and samples the DUT output. It records where capture first fails. The block sits between the digital control domain and the delay line / DUT pair on the characterization board.

## Interface
Parameters:
- `CODE_W`, 7: delay code width.
- `CODE_MAX`, 100: first (largest) code swept; must be ≤ 2^CODE_W−1.
- `TICK`, 4: clk cycles per phase; must be ≥ 2.
- `CNT_W`, 8: failure counter width.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a sweep.
- `dut_dout`  in  1  DUT flop output, already synchronous to `clk`. The block adds no synchronizer.
- `dut_din`  out  1  DUT data input.
- `cap_pulse`  out  1  one-cycle capture strobe, routed through the delay line to the DUT clock.
- `delay_code`  out  CODE_W  delay line setting.
- `busy`  out  1  high from start acceptance until `done`.
- `done`  out  1  one-cycle pulse at sweep end.
- `fail_found`  out  1  at least one step failed.
- `fail_code`  out  CODE_W  highest (first) failing code.
- `fail_count`  out  CNT_W  number of failing steps, saturating.

## Operation
- Reset values: `dut_din`=0, `cap_pulse`=0, `delay_code`=0, `busy`=0, `done`=0, `fail_found`=0, `fail_code`=0, `fail_count`=0. State returns to IDLE.
- States: IDLE, CLR, HOLD, LAUNCH, SETTLE, NEXT, FIN.
- IDLE:
  - `start`=1 → CLR.
  - `delay_code`←CODE_MAX, `busy`←1, and all result registers clear on acceptance.
  - `start` is ignored in every other state.
- CLR (TICK cycles): `dut_din`=0. `cap_pulse`=1 in the last cycle of CLR only.
- HOLD (TICK cycles): `dut_din`=0.
  - Init check: in the last HOLD cycle, sample `dut_dout`; expected 0.
- LAUNCH (1 cycle): `dut_din`=1 and `cap_pulse`=1 in the same cycle.
- SETTLE (TICK−1 cycles): `dut_din`=1.
  - Data check: in the last SETTLE cycle, sample `dut_dout`; expected 1.
- A step fails if either check mismatches. Each step is counted at most once.
- On the first failure:
  - `fail_found`←1 and `fail_code`←`delay_code`.
  - `fail_count` increments, saturating at all-ones.
- NEXT (1 cycle): `dut_din`←0.
  - Stop (failure without macro, or `delay_code`==0) → FIN.
  - Otherwise `delay_code` decrements → CLR.
- FIN: `done`=1 and `busy`←0 for one cycle → IDLE.
- After the sweep, `delay_code` and the results hold until the next accepted `start`.
- `delay_code` is stable for the whole step. It never underflows.

## Timing
- A step is 3·TICK+1 cycles: CLR TICK, HOLD TICK, LAUNCH 1, SETTLE TICK−1, NEXT 1.
- `start` sampled in cycle 0 → first CLR cycle is cycle 1.
- A full passing sweep asserts `done` at cycle (CODE_MAX+1)·(3·TICK+1)+1.
- With the defaults (CODE_MAX=100, TICK=4), that is cycle 1314.
- `cap_pulse` is never high in two consecutive cycles.
- `rst_n` low mid-sweep forces all outputs to their reset values immediately, with no `done` pulse. The sweep restarts only on a new `start`.
- CODE_MAX=0 gives a single step, `done` at cycle 3·TICK+2.

## Configuration
- `DFF_CHAR_SWEEP_ALL_EN` undefined:
  - The sweep stops after the first failing step.
  - `fail_count` is 0 or 1.
- `DFF_CHAR_SWEEP_ALL_EN` defined:
  - The sweep always runs down to code 0.
  - `fail_code` is the first (highest) failing code.
  - `fail_count` is the total number of failing steps.

## Test plan
The bench uses a behavioural DUT: it captures `dut_din` on `cap_pulse` only if `delay_code`≥K, else keeps its old value. Defaults: CODE_MAX=100, TICK=4.
- K=37, macro off, `start` → `done` after 65 steps, at cycle 65·13+1=846:
  - `fail_found`=1, `fail_code`=36, `fail_count`=1, `delay_code`=36.
- K=0 (always passes) → `done` at cycle 1314:
  - `fail_found`=0, `fail_count`=0, `delay_code`=0.
- K=37, macro on → `done` at cycle 1314:
  - `fail_code`=36, `fail_count`=37.
- `dut_dout` stuck at 1, macro off → init check fails at code 100:
  - `fail_code`=100, `fail_count`=1.
- Assert `start` again while `busy` at cycle 200 → ignored; the sweep completes unchanged.
- Pull `rst_n` low at cycle 500 for 3 cycles → all outputs at reset values immediately.
  - No `done` pulse.
  - A later `start` runs a full clean sweep.
